// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the store byte-lane mask helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } lsu_state_e;

    // size is funct3[1:0]: 0 = byte, 1 = half, 2 = word
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   lane_mask = 4'b0001 << offset;
            2'b01:   lane_mask = 4'b0011 << offset;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends
// it according to the load funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{offset, 3'b000} +: 8];
    assign half_sel = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the core data-memory port: one load/store at a time,
// registered memory strobes, aligned load return and access-error reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core_N,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Is_Store,
    input  logic [2:0]  Req_Funct3,
    input  logic [31:0] Req_Address,
    input  logic [31:0] Req_Store_Data,
    output logic        Resp_Valid,
    output logic [31:0] Resp_Load_Data,
    output logic        Resp_Misaligned,
    output logic        Resp_Fault,
    output logic        Read_Ctrl,
    output logic [3:0]  Write_Ctrl,
    output logic [31:0] Mem_Data_Address,
    output logic [31:0] Mem_Data_Write,
    input  logic [31:0] Mem_Data_Read
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_SIZE * 4);

    lsu_state_e  state, next_state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        mis_q, fault_q;
    logic [31:0] load_data_q;
    logic [31:0] aligned_data;

    logic        accept, issue;
    logic        req_fault, req_misaligned;
    logic [31:0] store_word;

    assign accept = Req_Valid && Req_Ready;
    assign issue  = accept && !req_fault && !req_misaligned;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        req_fault      = 1'b0;
        req_misaligned = 1'b0;
        store_word     = Req_Store_Data;

        if (Req_Is_Store) req_fault = (Req_Funct3 > F3_W);
        else              req_fault = (Req_Funct3 == 3'd3) || (Req_Funct3 >= 3'd6);
        if (Req_Address >= ADDR_LIMIT) req_fault = 1'b1;

        // A fault masks any alignment error on the same request
        if (!req_fault) begin
            case (Req_Funct3[1:0])
                2'b01:   req_misaligned = Req_Address[0];
                2'b10:   req_misaligned = |Req_Address[1:0];
                default: req_misaligned = 1'b0;
            endcase
        end

        case (Req_Funct3[1:0])
            2'b00:   store_word = {4{Req_Store_Data[7:0]}};
            2'b01:   store_word = {2{Req_Store_Data[15:0]}};
            default: store_word = Req_Store_Data;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = issue ? ISSUE : RESP;
            ISSUE:   next_state = is_store_q ? RESP : WAIT;
            WAIT:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    lsu_load_align u_load_align (
        .word   (Mem_Data_Read),
        .offset (offset_q),
        .funct3 (funct3_q),
        .data   (aligned_data)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state            <= IDLE;
            Req_Ready        <= 1'b1;
            Read_Ctrl        <= 1'b0;
            Write_Ctrl       <= 4'b0000;
            Mem_Data_Address <= '0;
            Mem_Data_Write   <= '0;
            Resp_Valid       <= 1'b0;
            Resp_Load_Data   <= '0;
            Resp_Misaligned  <= 1'b0;
            Resp_Fault       <= 1'b0;
            is_store_q       <= 1'b0;
            funct3_q         <= '0;
            offset_q         <= '0;
            mis_q            <= 1'b0;
            fault_q          <= 1'b0;
            load_data_q      <= '0;
        end else begin
            state     <= next_state;
            Req_Ready <= (next_state == IDLE);

            // Memory strobes live only in the ISSUE cycle
            Read_Ctrl        <= issue && !Req_Is_Store;
            Write_Ctrl       <= (issue && Req_Is_Store) ? lane_mask(Req_Funct3[1:0], Req_Address[1:0]) : 4'b0000;
            Mem_Data_Address <= issue ? {Req_Address[31:2], 2'b00} : '0;
            Mem_Data_Write   <= (issue && Req_Is_Store) ? store_word : '0;

            Resp_Valid      <= (state == RESP);
            Resp_Load_Data  <= (state == RESP) ? load_data_q : '0;
            Resp_Misaligned <= (state == RESP) && mis_q;
            Resp_Fault      <= (state == RESP) && fault_q;

            if (accept) begin
                is_store_q  <= Req_Is_Store;
                funct3_q    <= Req_Funct3;
                offset_q    <= Req_Address[1:0];
                mis_q       <= req_misaligned;
                fault_q     <= req_fault;
                load_data_q <= '0;
            end
            if (state == WAIT) load_data_q <= aligned_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory model,
// per-cycle compare of all outputs, directed scenarios plus random traffic.
module tb_load_store_unit;

    localparam int MEM_SIZE = 256;
    localparam int MAXC     = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_address, req_store_data;
    logic        resp_valid, resp_misaligned, resp_fault;
    logic [31:0] resp_load_data;
    logic        read_ctrl;
    logic [3:0]  write_ctrl;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .Clk_Core         (clk),
        .Rst_Core_N       (rst_n),
        .Req_Valid        (req_valid),
        .Req_Ready        (req_ready),
        .Req_Is_Store     (req_is_store),
        .Req_Funct3       (req_funct3),
        .Req_Address      (req_address),
        .Req_Store_Data   (req_store_data),
        .Resp_Valid       (resp_valid),
        .Resp_Load_Data   (resp_load_data),
        .Resp_Misaligned  (resp_misaligned),
        .Resp_Fault       (resp_fault),
        .Read_Ctrl        (read_ctrl),
        .Write_Ctrl       (write_ctrl),
        .Mem_Data_Address (mem_addr),
        .Mem_Data_Write   (mem_wdata),
        .Mem_Data_Read    (mem_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: word-addressed, byte-enabled, registered read; garbage when not read
    logic [31:0] mem_words [MEM_SIZE];
    logic [31:0] rdata;
    logic        mem_clear;
    assign mem_rdata = rdata;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < MEM_SIZE; i++) mem_words[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (write_ctrl[i]) mem_words[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        if (read_ctrl) rdata <= mem_words[mem_addr[9:2]];
        else           rdata <= $urandom;
    end

    // Reference model state and per-cycle expectations
    bit [7:0]  ref_mem   [MEM_SIZE*4];
    bit        exp_rv    [MAXC];
    bit [31:0] exp_data  [MAXC];
    bit        exp_mis   [MAXC];
    bit        exp_fault [MAXC];
    bit        exp_busy  [MAXC];
    bit        exp_rd    [MAXC];
    bit [3:0]  exp_wr    [MAXC];
    bit [31:0] exp_addr  [MAXC];
    bit [31:0] exp_wdata [MAXC];

    int tests = 0;
    int fails = 0;
    bit checking = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Computes what the access must do from the architectural rules and records the schedule
    task automatic model(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] data, input int a, output int lat);
        bit        fault, mis;
        int        sz;
        bit [31:0] raw, val;
        if (st) fault = (f3 > 3'd2);
        else    fault = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        if (addr >= 32'(MEM_SIZE*4)) fault = 1'b1;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis = !fault && ((addr % sz) != 0);
        val = 0;
        if (fault || mis) lat = 1;
        else if (st)      lat = 2;
        else              lat = 3;
        if (!fault && !mis) begin
            exp_addr[a] = addr & 32'hFFFF_FFFC;
            if (st) begin
                for (int i = 0; i < sz; i++) ref_mem[addr + i] = data[8*i +: 8];
                exp_wr[a] = 4'(((1 << sz) - 1) << addr[1:0]);
                for (int j = 0; j < 4; j++) exp_wdata[a][8*j +: 8] = data[8*(j % sz) +: 8];
            end else begin
                raw = 0;
                for (int i = 0; i < sz; i++) raw = raw | (32'(ref_mem[addr + i]) << (8*i));
                val = raw;
                if (!f3[2] && sz < 4 && raw[8*sz-1]) val = raw | (32'hFFFF_FFFF << (8*sz));
                exp_rd[a] = 1'b1;
            end
        end
        exp_rv[a+lat]    = 1'b1;
        exp_data[a+lat]  = val;
        exp_mis[a+lat]   = mis;
        exp_fault[a+lat] = fault;
        for (int c = a; c < a + lat; c++) exp_busy[c] = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge with Req_Valid still high
    task automatic issue(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] data, output int a, output int lat);
        int budget = 0;
        req_valid      = 1'b1;
        req_is_store   = st;
        req_funct3     = f3;
        req_address    = addr;
        req_store_data = data;
        while (!req_ready) begin
            @(negedge clk);
            budget++;
            if (budget > 50) begin
                fails++;
                $display("FAIL ready_timeout @cyc %0d: got 0, want 1", cyc);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $fatal(1, "request never accepted");
            end
        end
        a = cyc + 1;
        model(st, f3, addr, data, a, lat);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Per-cycle compare of every output against the model's schedule
    always @(negedge clk) begin
        if (checking && cyc < MAXC) begin
            check("resp_valid", 32'(resp_valid), 32'(exp_rv[cyc]));
            check("resp_data", resp_load_data, exp_rv[cyc] ? exp_data[cyc] : 32'h0);
            check("resp_misaligned", 32'(resp_misaligned), 32'(exp_rv[cyc] && exp_mis[cyc]));
            check("resp_fault", 32'(resp_fault), 32'(exp_rv[cyc] && exp_fault[cyc]));
            check("req_ready", 32'(req_ready), 32'(!exp_busy[cyc]));
            check("read_ctrl", 32'(read_ctrl), 32'(exp_rd[cyc]));
            check("write_ctrl", 32'(write_ctrl), 32'(exp_wr[cyc]));
            if (exp_rd[cyc] || exp_wr[cyc] != 4'b0) check("mem_addr", mem_addr, exp_addr[cyc]);
            if (exp_wr[cyc] != 4'b0) check("mem_wdata", mem_wdata, exp_wdata[cyc]);
        end
    end

    initial begin
        int a, lat;
        int acc [4];
        bit st;
        bit [2:0] f3;
        bit [31:0] addr;
        int r;

        rst_n = 1'b0;
        mem_clear = 1'b1;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = '0;
        req_address = '0;
        req_store_data = '0;
        for (int i = 0; i < MEM_SIZE*4; i++) ref_mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_write_ctrl", 32'(write_ctrl), 32'h0);
        check("rst_read_ctrl", 32'(read_ctrl), 32'h0);
        mem_clear = 1'b0;
        rst_n = 1'b1;
        checking = 1'b1;
        @(negedge clk);

        // SW then LW at 0x10
        issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, a, lat);
        check("sw_wc", 32'(write_ctrl), 32'hF);
        idle(1);
        check("sw_wc_one_cycle", 32'(write_ctrl), 32'h0);
        idle(3);
        issue(1'b0, 3'd2, 32'h10, 32'h0, a, lat);
        idle(0);
        wait_until(a + 3);
        check("lw_valid", 32'(resp_valid), 32'h1);
        check("lw_data", resp_load_data, 32'hDEAD_BEEF);
        idle(2);

        // SB 0x80 at 0x13, LB and LBU back
        issue(1'b1, 3'd0, 32'h13, 32'h0000_0080, a, lat);
        check("sb_wc", 32'(write_ctrl), 32'h8);
        check("sb_wdata", mem_wdata, 32'h8080_8080);
        idle(3);
        issue(1'b0, 3'd0, 32'h13, 32'h0, a, lat);
        idle(0);
        wait_until(a + 3);
        check("lb_data", resp_load_data, 32'hFFFF_FF80);
        idle(2);
        issue(1'b0, 3'd4, 32'h13, 32'h0, a, lat);
        idle(0);
        wait_until(a + 3);
        check("lbu_data", resp_load_data, 32'h0000_0080);
        idle(2);

        // SH 0x8001 at 0x12, LH back, then misaligned LH at 0x11
        issue(1'b1, 3'd1, 32'h12, 32'h0000_8001, a, lat);
        check("sh_wc", 32'(write_ctrl), 32'hC);
        idle(3);
        issue(1'b0, 3'd1, 32'h12, 32'h0, a, lat);
        idle(0);
        wait_until(a + 3);
        check("lh_data", resp_load_data, 32'hFFFF_8001);
        idle(2);
        issue(1'b0, 3'd1, 32'h11, 32'h0, a, lat);
        check("lh_mis_no_read", 32'(read_ctrl), 32'h0);
        idle(0);
        wait_until(a + 1);
        check("lh_mis_flag", 32'(resp_misaligned), 32'h1);
        check("lh_mis_nofault", 32'(resp_fault), 32'h0);
        idle(2);

        // Out-of-range and illegal funct3 loads
        issue(1'b0, 3'd2, 32'h400, 32'h0, a, lat);
        check("oor_no_read", 32'(read_ctrl), 32'h0);
        idle(0);
        wait_until(a + 1);
        check("oor_fault", 32'(resp_fault), 32'h1);
        idle(2);
        issue(1'b0, 3'd3, 32'h8, 32'h0, a, lat);
        idle(0);
        wait_until(a + 1);
        check("f3_fault", 32'(resp_fault), 32'h1);
        idle(2);

        // Reset during the ISSUE cycle of a store
        req_valid = 1'b1;
        req_is_store = 1'b1;
        req_funct3 = 3'd2;
        req_address = 32'h20;
        req_store_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("abort_wc_issue", 32'(write_ctrl), 32'hF);
        req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_wc_cleared", 32'(write_ctrl), 32'h0);
        check("abort_ready", 32'(req_ready), 32'h1);
        check("abort_no_resp", 32'(resp_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        check("abort_mem_word", mem_words[8],
              {ref_mem[32'h23], ref_mem[32'h22], ref_mem[32'h21], ref_mem[32'h20]});
        issue(1'b0, 3'd2, 32'h20, 32'h0, a, lat);
        idle(4);

        // Back-to-back loads with Req_Valid held high
        for (int i = 0; i < 4; i++) issue(1'b0, 3'd2, 32'h10, 32'h0, acc[i], lat);
        idle(5);
        for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd4);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 8) f3 = st ? 3'($urandom_range(0, 2)) : 3'(r % 2 == 0 ? $urandom_range(0, 2) : $urandom_range(4, 5));
            else       f3 = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 15);
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = 32'(1024 - $urandom_range(0, 4));
            else             addr = 32'($urandom_range(0, 127));
            issue(st, f3, addr, $urandom, a, lat);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(8);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
